// File: rtl/roi_buffer_sequencer.sv
// Ping-pong bank / address sequencer for the KLT previous-frame ROI buffer.
// Optional macro DISP_CLAMP_EN: saturate displacement instead of invalidating the frame.
module roi_buffer_sequencer #(
  parameter int NEIGH_SIZE   = 10,
  parameter int BORDER_WIDTH = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [11:0] point_x0,
  input  logic [10:0] point_y0,
  input  logic        in_extended_roi,
  input  logic        in_roi,
  input  logic        err_clr,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic        rd_en,
  output logic [10:0] rd_addr,
  output logic        prev_pixel_valid,
  output logic        prev_frame_ok,
  output logic [2:0]  err_status
);

  localparam int ROI_W   = 2*NEIGH_SIZE + 1;
  localparam int EXT_W   = ROI_W + 2*BORDER_WIDTH;
  localparam int ROI_PIX = ROI_W*ROI_W;
  localparam int EXT_PIX = EXT_W*EXT_W;

  localparam logic [9:0]         EXT_PIX_C = 10'(EXT_PIX);
  localparam logic [8:0]         ROI_PIX_C = 9'(ROI_PIX);
  localparam logic [4:0]         ROI_LAST  = 5'(ROI_W - 1);
  localparam logic [9:0]         ROW_SKIP  = 10'(EXT_W - ROI_W + 1);
  localparam logic [15:0]        BW16      = 16'(BORDER_WIDTH);
  localparam logic [15:0]        EXTW16    = 16'(EXT_W);
  localparam logic signed [11:0] BWX       = 12'(BORDER_WIDTH);
  localparam logic signed [10:0] BWY       = 11'(BORDER_WIDTH);

  typedef enum logic {NO_PREV, TRACKING} state_t;

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_wcnt, r_raddr;
  logic [8:0]  r_rcnt;
  logic [4:0]  r_rcol;
  logic        r_wr_bank;
  logic [11:0] r_cur_x0;
  logic [10:0] r_cur_y0;
  logic [2:0]  r_err;
  logic [READ_LATENCY:1] r_vld_pipe;
  logic [READ_LATENCY:0] w_vld_pipe;

  logic              w_wfull, w_rfull, w_disp_ok;
  logic signed [11:0] w_dx, w_dxc;
  logic signed [10:0] w_dy, w_dyc;
  logic [15:0]        w_base;
  logic [2:0]         w_err_set;

  assign w_wfull = (r_wcnt == EXT_PIX_C);
  assign w_rfull = (r_rcnt == ROI_PIX_C);
  assign w_dx    = $signed(point_x0 - r_cur_x0);
  assign w_dy    = $signed(point_y0 - r_cur_y0);

  always_comb begin
    w_dxc     = w_dx;
    w_dyc     = w_dy;
    w_disp_ok = 1'b1;
`ifdef DISP_CLAMP_EN
    if (w_dx > BWX)       w_dxc = BWX;
    else if (w_dx < -BWX) w_dxc = -BWX;
    if (w_dy > BWY)       w_dyc = BWY;
    else if (w_dy < -BWY) w_dyc = -BWY;
`else
    w_disp_ok = (w_dx >= -BWX) && (w_dx <= BWX) && (w_dy >= -BWY) && (w_dy <= BWY);
`endif
  end

  // Modular 16-bit math; only the low 10 bits land in raddr.
  assign w_base = (BW16 + {{5{w_dyc[10]}}, w_dyc}) * EXTW16 + BW16 + {{4{w_dxc[11]}}, w_dxc};

  assign prev_frame_ok = (r_state == TRACKING);
  assign wr_en   = in_extended_roi & ~frame_start & ~w_wfull;
  assign rd_en   = in_roi & prev_frame_ok & ~w_rfull;
  assign wr_addr = {r_wr_bank, r_wcnt};
  assign rd_addr = {~r_wr_bank, r_raddr};
  assign err_status = r_err;

  assign w_err_set[0] = in_extended_roi & w_wfull;
  assign w_err_set[1] = in_roi & prev_frame_ok & w_rfull;
  assign w_err_set[2] = frame_start & (~w_wfull | in_extended_roi);

  always_comb begin
    w_state_nxt = r_state;
    if (frame_start)
      w_state_nxt = (w_wfull && w_disp_ok) ? TRACKING : NO_PREV;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= NO_PREV;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt    <= '0;
      r_raddr   <= '0;
      r_rcnt    <= '0;
      r_rcol    <= '0;
      r_wr_bank <= 1'b0;
      r_cur_x0  <= '0;
      r_cur_y0  <= '0;
    end else if (frame_start) begin
      if (w_wfull) r_wr_bank <= ~r_wr_bank;
      r_raddr  <= w_base[9:0];
      r_cur_x0 <= point_x0;
      r_cur_y0 <= point_y0;
      r_wcnt   <= '0;
      r_rcnt   <= '0;
      r_rcol   <= '0;
    end else begin
      if (wr_en) r_wcnt <= r_wcnt + 10'd1;
      if (rd_en) begin
        r_rcnt <= r_rcnt + 9'd1;
        // Row wrap jumps over the border columns of the extended ROI.
        if (r_rcol == ROI_LAST) begin
          r_rcol  <= '0;
          r_raddr <= r_raddr + ROW_SKIP;
        end else begin
          r_rcol  <= r_rcol + 5'd1;
          r_raddr <= r_raddr + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= '0;
    else        r_err <= (err_clr ? 3'b000 : r_err) | w_err_set;
  end

  assign w_vld_pipe[0] = rd_en;
  assign w_vld_pipe[READ_LATENCY:1] = r_vld_pipe;
  assign prev_pixel_valid = r_vld_pipe[READ_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_pipe <= '0;
    else        r_vld_pipe <= w_vld_pipe[READ_LATENCY-1:0];
  end

endmodule

// File: tb/tb_roi_buffer_sequencer.sv
// Directed self-checking bench for roi_buffer_sequencer (default parameters).
module tb_roi_buffer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [11:0] point_x0;
  logic [10:0] point_y0;
  logic        in_extended_roi, in_roi, err_clr;
  logic        wr_en, rd_en, prev_pixel_valid, prev_frame_ok;
  logic [10:0] wr_addr, rd_addr;
  logic [2:0]  err_status;

  int checks = 0;
  int failures = 0;

  roi_buffer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .point_x0(point_x0), .point_y0(point_y0),
    .in_extended_roi(in_extended_roi), .in_roi(in_roi), .err_clr(err_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .prev_pixel_valid(prev_pixel_valid), .prev_frame_ok(prev_frame_ok),
    .err_status(err_status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic fstart(input logic [11:0] x, input logic [10:0] y);
    point_x0 = x; point_y0 = y; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Drives nw write strobes and nr read strobes from cycle 0, comparing every
  // cycle against the expected address sequence and 2-cycle valid delay.
  task automatic do_frame(input string tag, input int nw, input int nr, input int rbase,
                          input bit rbank, input bit wbank, input bit rd_ok);
    int bad = 0;
    int first_bad = -1;
    bit h1 = 0, h2 = 0;
    int n = (nw > nr) ? nw : nr;
    for (int k = 0; k < n; k++) begin
      bit ew, er;
      int ewa, era;
      in_extended_roi = (k < nw);
      in_roi = (k < nr);
      #1;
      ew  = (k < nw) && (k < 625);
      er  = rd_ok && (k < nr) && (k < 441);
      ewa = (wbank ? 1024 : 0) + k;
      era = (rbank ? 1024 : 0) + rbase + (k / 21) * 25 + (k % 21);
      if (wr_en !== ew || (ew && int'(wr_addr) != ewa) ||
          rd_en !== er || (er && int'(rd_addr) != era) ||
          prev_pixel_valid !== h2) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      h2 = h1; h1 = er;
      @(posedge clk); #1;
    end
    in_extended_roi = 1'b0;
    in_roi = 1'b0;
    chk({tag, "_bad_cycles"}, bad, 0);
    chk({tag, "_first_bad"}, first_bad, -1);
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; point_x0 = '0; point_y0 = '0;
    in_extended_roi = 1'b0; in_roi = 1'b0; err_clr = 1'b0;
    idle(2);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 11'h000);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 11'h400);
    chk("rst_pv", prev_pixel_valid, 0);
    chk("rst_ok", prev_frame_ok, 0);
    chk("rst_err", err_status, 3'b000);
    rst_n = 1'b1;
    step();

    // First frame_start after reset finds an empty bank -> incomplete flag.
    fstart(12'd100, 11'd50);
    chk("f1_err", err_status, 3'b100);
    chk("f1_ok", prev_frame_ok, 0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("f1_errclr", err_status, 3'b000);
    idle(2);
    do_frame("f1", 625, 441, 0, 1'b1, 1'b0, 1'b0);
    chk("f1_ok_end", prev_frame_ok, 0);

    // Same point: complete bank, dx=dy=0 -> base 52.
    fstart(12'd100, 11'd50);
    chk("f2_ok", prev_frame_ok, 1);
    chk("f2_wr_addr", wr_addr, 11'h400);
    chk("f2_rd_addr", rd_addr, 11'd52);
    chk("f2_err", err_status, 3'b000);
    idle(2);
    do_frame("f2", 625, 442, 52, 1'b0, 1'b1, 1'b1);
    chk("f2_rd_overrun", err_status, 3'b010);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("f2_errclr", err_status, 3'b000);

    // dx=+1, dy=-1 -> base 28; row end 48, next row 53.
    fstart(12'd101, 11'd49);
    chk("f3_ok", prev_frame_ok, 1);
    chk("f3_rd_addr", rd_addr, 11'h41C);
    chk("f3_wr_addr", wr_addr, 11'h000);
    idle(2);
    do_frame("f3", 625, 22, 28, 1'b1, 1'b0, 1'b1);

    // dx=+3 exceeds the border.
    fstart(12'd104, 11'd49);
    chk("f4_err", err_status, 3'b000);
    chk("f4_wr_addr", wr_addr, 11'h400);
`ifdef DISP_CLAMP_EN
    chk("f4_ok", prev_frame_ok, 1);
    chk("f4_rd_addr", rd_addr, 11'd54);
    idle(2);
    do_frame("f4", 626, 21, 54, 1'b0, 1'b1, 1'b1);
`else
    chk("f4_ok", prev_frame_ok, 0);
    idle(2);
    do_frame("f4", 626, 21, 54, 1'b0, 1'b1, 1'b0);
`endif
    chk("f4_wr_overrun", err_status, 3'b001);

    // Full bank -> toggle back to bank 0; overrun alone is not an incomplete frame.
    fstart(12'd104, 11'd49);
    chk("f5_wr_addr", wr_addr, 11'h000);
    chk("f5_ok", prev_frame_ok, 1);
    chk("f5_err", err_status, 3'b001);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("f5_errclr", err_status, 3'b000);
    idle(2);
    do_frame("f5", 300, 0, 52, 1'b1, 1'b0, 1'b1);

    // Incomplete frame, frame_start colliding with a write, set beats clear.
    point_x0 = 12'd104; point_y0 = 11'd49;
    frame_start = 1'b1; in_extended_roi = 1'b1; err_clr = 1'b1;
    #1;
    chk("f6_wr_en_collide", wr_en, 0);
    step();
    frame_start = 1'b0; in_extended_roi = 1'b0; err_clr = 1'b0;
    chk("f6_err", err_status, 3'b100);
    chk("f6_ok", prev_frame_ok, 0);
    chk("f6_wr_addr", wr_addr, 11'h000);
    chk("f6_rd_addr", rd_addr, 11'h434);

    // Asynchronous reset mid-frame.
    do_frame("f7", 10, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("f7_wr_addr_pre", wr_addr, 11'h00A);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_addr", wr_addr, 11'h000);
    chk("arst_rd_addr", rd_addr, 11'h400);
    chk("arst_ok", prev_frame_ok, 0);
    chk("arst_err", err_status, 3'b000);
    chk("arst_pv", prev_pixel_valid, 0);
    rst_n = 1'b1;
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/roi_buffer_sequencer.md
Name: roi_buffer_sequencer

Overview:
Address and bank sequencer for the previous-frame ROI buffer memory of the KLT point tracker. Ping-pongs two banks of the dual-port BRAM: the current frame's extended ROI is written into one bank while the previous frame's inner ROI is read from the other. The read window is shifted by the frame-to-frame displacement of the tracked point. Sits between the ROI window generator (in_roi / in_extended_roi) and the buffer BRAM (port A write, port B read).

Parameters:
NEIGH_SIZE, 10, inner ROI half-size; ROI_W = 2*NEIGH_SIZE+1 = 21, ROI_PIX = 441
BORDER_WIDTH, 2, extra border; EXT_W = ROI_W+2*BORDER_WIDTH = 25, EXT_PIX = 625
READ_LATENCY, 2, BRAM port B read latency in clk cycles

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at the start of each frame (vsync)
point_x0  in  12  ROI origin x for the starting frame; stable when frame_start=1
point_y0  in  11  ROI origin y for the starting frame; stable when frame_start=1
in_extended_roi  in  1  current pixel lies in the extended ROI (write strobe)
in_roi  in  1  current pixel lies in the inner ROI (read strobe)
err_clr  in  1  clears err_status
wr_en  out  1  BRAM port A write enable
wr_addr  out  11  {wr_bank, wcnt[9:0]}
rd_en  out  1  BRAM port B enable
rd_addr  out  11  {~wr_bank, raddr[9:0]}
prev_pixel_valid  out  1  rd_en delayed READ_LATENCY cycles; qualifies BRAM doutb
prev_frame_ok  out  1  previous-frame bank holds a complete, usable ROI
err_status  out  3  sticky: [0] write overrun, [1] read overrun, [2] incomplete frame or frame_start/write collision

Behaviour:
- Reset: wcnt=0, raddr=0, rcol=0, rcnt=0, wr_bank=0, cur_x0/cur_y0=0, prev_frame_ok=0, err_status=0, delay pipe=0. All outputs therefore 0 except rd_addr = 11'h400.
- wr_en = in_extended_roi & ~frame_start & (wcnt<EXT_PIX), combinational. wr_addr is combinational from the registers. On a write, wcnt increments.
- in_extended_roi with wcnt==EXT_PIX: no write, err_status[0]<=1.
- rd_en = in_roi & prev_frame_ok & (rcnt<ROI_PIX), combinational.
- On a read: rcnt++. If rcol==ROI_W-1, then rcol<=0 and raddr += EXT_W-ROI_W+1 (=5). Otherwise rcol++ and raddr++.
- in_roi with prev_frame_ok=1 and rcnt==ROI_PIX: no read, err_status[1]<=1.
- frame_start, evaluated in one cycle; frame_start has priority over writes:
  - wcnt==EXT_PIX: wr_bank toggles, prev_frame_ok<=1.
  - Otherwise: prev_frame_ok<=0, err_status[2]<=1, bank kept.
  - dx = point_x0 - cur_x0 (12-bit signed), dy = point_y0 - cur_y0 (11-bit signed).
  - raddr <= (BORDER_WIDTH+dy)*EXT_W + (BORDER_WIDTH+dx); range 0..104 with defaults.
  - cur_x0/cur_y0 <= point; wcnt, rcnt, rcol <= 0.
  - in_extended_roi=1 in the same cycle: write dropped, err_status[2]<=1.
- Displacement out of range (|dx| or |dy| > BORDER_WIDTH): handled per Optional Feature.
- err_clr: clears all err bits. A set event in the same cycle wins over the clear.
- prev_pixel_valid: READ_LATENCY-stage shift register of rd_en, cleared by reset.
- States:
  - NO_PREV: after reset or an incomplete/invalid frame; prev_frame_ok=0.
  - TRACKING: prev_frame_ok=1.
  - Transitions occur only at frame_start, per the rules above.

Optional Feature:
DISP_CLAMP_EN defined: dx and dy are saturated to ±BORDER_WIDTH before computing the base; prev_frame_ok follows the completeness rule only.
DISP_CLAMP_EN undefined: an out-of-range dx or dy forces prev_frame_ok<=0 for that frame; reads are suppressed and no error bit is set.

Test Plan:
- Reset, frame 1 with 625 in_extended_roi and 441 in_roi pulses -> wr_addr 0..624 in bank 0; rd_en never 1; prev_frame_ok=0 throughout.
- frame_start with the same point, then frame 2 -> prev_frame_ok=1; writes go to bank 1 (wr_addr 0x400..). rd_addr sequence 52..72, 77..97, ... ends at 572 after 441 reads. prev_pixel_valid lags rd_en by exactly 2 cycles.
- Frame 3 point moves dx=+1, dy=-1 -> first rd_addr = {bank, 28}; first row end 48, next 53.
- dx=+3, dy=0 -> with DISP_CLAMP_EN first raddr=54; without it prev_frame_ok=0 and rd_en stays 0.
- 626 write strobes in one frame -> 626th has wr_en=0 and err_status=3'b001. Next frame_start toggles the bank. err_clr -> 3'b000.
- Only 300 writes, then frame_start -> no bank toggle, prev_frame_ok=0, err_status[2]=1. rst_n low mid-frame -> all outputs return to reset values asynchronously.
